// File: rtl/nserial_pkg.sv
// Shared constants and state encoding for the Nintendo single-wire serial transmitter.
package nserial_pkg;

    localparam int unsigned QUARTERS = 4;
    localparam int unsigned ZERO_LOW = 3;
    localparam int unsigned ONE_LOW  = 1;
    localparam int unsigned STOP_LOW = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIT,
        S_STOP
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/nintendo_serial_tx_if.sv
// Upstream enqueue handshake between a controller and its serial transmitter.
interface nintendo_serial_tx_if;

    logic       tx_strobe;
    logic       tx_stopbit;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       overrun;

    modport master (
        output tx_strobe,
        output tx_stopbit,
        output tx_data,
        input  tx_busy,
        input  overrun
    );

    modport slave (
        input  tx_strobe,
        input  tx_stopbit,
        input  tx_data,
        output tx_busy,
        output overrun
    );

endinterface

// File: rtl/nserial_bit_shaper.sv
// Maps a data bit or stop flag plus quarter index onto the line level for that quarter.
module nserial_bit_shaper #(
    parameter int unsigned QUARTERS = nserial_pkg::QUARTERS,
    parameter int unsigned ZERO_LOW = nserial_pkg::ZERO_LOW,
    parameter int unsigned ONE_LOW  = nserial_pkg::ONE_LOW,
    parameter int unsigned STOP_LOW = nserial_pkg::STOP_LOW,
    localparam int unsigned QW      = (QUARTERS > 1) ? $clog2(QUARTERS) : 1
) (
    input  logic          bit_val,
    input  logic          stop,
    input  logic [QW-1:0] quarter,
    output logic          level
);

    always_comb begin
        int unsigned low_count;
        low_count = ZERO_LOW;
        if (stop) begin
            low_count = STOP_LOW;
        end else if (bit_val) begin
            low_count = ONE_LOW;
        end
        level = (32'(quarter) < low_count) ? 1'b0 : 1'b1;
    end

endmodule

// File: rtl/nintendo_serial_tx.sv
// Double-buffered Nintendo serial transmitter: holding register, bit/quarter counters
// and a shifter FSM paced by the shared quarter-bit tick.
module nintendo_serial_tx
    import nserial_pkg::*;
#(
    parameter int unsigned QUARTERS = nserial_pkg::QUARTERS,
    parameter int unsigned ZERO_LOW = nserial_pkg::ZERO_LOW,
    parameter int unsigned ONE_LOW  = nserial_pkg::ONE_LOW,
    parameter int unsigned STOP_LOW = nserial_pkg::STOP_LOW,
    localparam int unsigned QW      = (QUARTERS > 1) ? $clog2(QUARTERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_tick,
    nintendo_serial_tx_if.slave  bus,
    output logic                 tx,
    output logic                 tx_active
);

    state_t        state, state_d;
    logic [7:0]    shift, shift_d;
    logic [QW-1:0] quarter, quarter_d;
    logic [2:0]    bit_count, bit_count_d;
    logic          hold_full, hold_stop;
    logic [7:0]    hold_data;
    logic          load, end_frame, last_quarter, accept, level;

    always_comb begin
        state_d      = state;
        shift_d      = shift;
        quarter_d    = quarter;
        bit_count_d  = bit_count;
        load         = 1'b0;
        end_frame    = 1'b0;
        last_quarter = (quarter == QW'(QUARTERS - 1));
        if (tx_tick) begin
            unique case (state)
                S_IDLE: load = hold_full;
                S_BIT: begin
                    if (!last_quarter) begin
                        quarter_d = quarter + QW'(1);
                    end else if (bit_count == 3'd7) begin
                        end_frame = 1'b1;
                    end else begin
                        quarter_d   = '0;
                        bit_count_d = bit_count + 3'd1;
                        shift_d     = {shift[6:0], 1'b0};
                    end
                end
                S_STOP: begin
                    if (last_quarter) begin
                        end_frame = 1'b1;
                    end else begin
                        quarter_d = quarter + QW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (end_frame) begin
                // Chain straight into the next entry so back-to-back frames stay gapless.
                load    = hold_full;
                state_d = S_IDLE;
            end
            if (load) begin
                state_d     = hold_stop ? S_STOP : S_BIT;
                shift_d     = hold_data;
                quarter_d   = '0;
                bit_count_d = '0;
            end
        end
    end

    // A strobe landing on the emptying clk refills the holding register, not an overrun.
    assign accept = bus.tx_strobe && (!hold_full || load);

    nserial_bit_shaper #(
        .QUARTERS (QUARTERS),
        .ZERO_LOW (ZERO_LOW),
        .ONE_LOW  (ONE_LOW),
        .STOP_LOW (STOP_LOW)
    ) u_shaper (
        .bit_val (shift_d[7]),
        .stop    (state_d == S_STOP),
        .quarter (quarter_d),
        .level   (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            shift       <= '0;
            quarter     <= '0;
            bit_count   <= '0;
            hold_full   <= 1'b0;
            hold_stop   <= 1'b0;
            hold_data   <= '0;
            bus.overrun <= 1'b0;
            tx          <= IDLE_LEVEL;
        end else begin
            state       <= state_d;
            shift       <= shift_d;
            quarter     <= quarter_d;
            bit_count   <= bit_count_d;
            hold_full   <= accept | (hold_full & ~load);
            bus.overrun <= bus.tx_strobe & hold_full & ~load;
            tx          <= (state_d == S_IDLE) ? IDLE_LEVEL : level;
            if (accept) begin
                hold_data <= bus.tx_data;
                hold_stop <= bus.tx_stopbit;
            end
        end
    end

    assign bus.tx_busy = hold_full;
    assign tx_active   = hold_full | (state != S_IDLE);

endmodule

// File: tb/tb_nintendo_serial_tx.sv
// Directed bench for nintendo_serial_tx: captures the line once per quarter tick and
// compares it against hand-built quarter patterns.
module tb_nintendo_serial_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_tick = 1'b0;
    logic tx;
    logic tx_active;

    nintendo_serial_tx_if bus ();

    nintendo_serial_tx dut (
        .clk       (clk),
        .reset     (reset),
        .tx_tick   (tx_tick),
        .bus       (bus),
        .tx        (tx),
        .tx_active (tx_active)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ovr_cnt  = 0;
    logic cap[$];
    logic exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // One clk: drive at negedge, tick every 4th clk, sample 1 time unit after posedge.
    task automatic cycle(input logic stb, input logic stop, input logic [7:0] d);
        @(negedge clk);
        cyc++;
        tx_tick        = (cyc % 4 == 0);
        bus.tx_strobe  = stb;
        bus.tx_stopbit = stop;
        bus.tx_data    = d;
        @(posedge clk);
        #1;
        if (tx_tick) cap.push_back(tx);
        if (bus.overrun) ovr_cnt++;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            idle();
            if (tx_tick) seen++;
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (bus.tx_busy && k < 200) begin
            idle();
            k++;
        end
        check(tag, (k < 200), 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (tx_active && k < 2000) begin
            idle();
            k++;
        end
        check(tag, (k < 2000), 1);
    endtask

    function automatic void add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            int lowq = b[i] ? 1 : 3;
            for (int q = 0; q < 4; q++) exp_q.push_back((q < lowq) ? 1'b0 : 1'b1);
        end
    endfunction

    function automatic void add_stop();
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endfunction

    function automatic void clear_capture();
        cap.delete();
        exp_q.delete();
    endfunction

    task automatic compare(input string tag);
        logic [127:0] g = '0;
        logic [127:0] w = '0;
        foreach (cap[i]) g = {g[126:0], cap[i]};
        foreach (exp_q[i]) w = {w[126:0], exp_q[i]};
        check({tag, "_len"}, cap.size(), exp_q.size());
        check(tag, g, w);
    endtask

    initial begin
        bus.tx_strobe  = 1'b0;
        bus.tx_stopbit = 1'b0;
        bus.tx_data    = 8'h00;

        // Reset state
        repeat (2) idle();
        check("rst_tx", tx, 1);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_active", tx_active, 0);
        check("rst_overrun", bus.overrun, 0);
        #2 reset = 1'b0;

        // 0x80: one short-low bit then seven long-low bits
        run_ticks(1);
        clear_capture();
        check("t1_busy_pre", bus.tx_busy, 0);
        cycle(1'b1, 1'b0, 8'h80);
        check("t1_busy_strobe", bus.tx_busy, 1);
        check("t1_tx_wait", tx, 1);
        run_ticks(1);
        check("t1_busy_load", bus.tx_busy, 0);
        check("t1_tx_q0", tx, 0);
        check("t1_active", tx_active, 1);
        wait_idle("t1_idle");
        add_byte(8'h80);
        add_idle(1);
        compare("t1_frame");
        check("t1_tx_end", tx, 1);

        // Controller ID poll: 0x09 0x00 0x00 stop, gapless
        run_ticks(1);
        clear_capture();
        cycle(1'b1, 1'b0, 8'h09);
        wait_ready("t2_rdy1");
        cycle(1'b1, 1'b0, 8'h00);
        wait_ready("t2_rdy2");
        cycle(1'b1, 1'b0, 8'h00);
        wait_ready("t2_rdy3");
        cycle(1'b1, 1'b1, 8'h00);
        wait_idle("t2_idle");
        add_byte(8'h09);
        add_byte(8'h00);
        add_byte(8'h00);
        add_stop();
        add_idle(1);
        compare("t2_frame");
        check("t2_tx_end", tx, 1);
        check("t2_active_end", tx_active, 0);

        // Overrun: second strobe while holding is full is dropped
        run_ticks(1);
        clear_capture();
        ovr_cnt = 0;
        cycle(1'b1, 1'b0, 8'h55);
        cycle(1'b1, 1'b0, 8'hAA);
        check("t3_ovr_pulse", bus.overrun, 1);
        idle();
        check("t3_ovr_clear", bus.overrun, 0);
        wait_idle("t3_idle");
        check("t3_ovr_count", ovr_cnt, 1);
        add_byte(8'h55);
        add_idle(1);
        compare("t3_frame");

        // 0xFF, three idle ticks, then 0x00
        run_ticks(1);
        clear_capture();
        cycle(1'b1, 1'b0, 8'hFF);
        run_ticks(35);
        check("t4_gap_tx", tx, 1);
        check("t4_gap_active", tx_active, 0);
        cycle(1'b1, 1'b0, 8'h00);
        wait_idle("t4_idle");
        add_byte(8'hFF);
        add_idle(3);
        add_byte(8'h00);
        add_idle(1);
        compare("t4_frame");

        // Reset during bit 4 of 0xF0 with holding full and overrun pulsing
        run_ticks(1);
        clear_capture();
        cycle(1'b1, 1'b0, 8'hF0);
        run_ticks(18);
        check("t5_tx_bit4", tx, 0);
        cycle(1'b1, 1'b0, 8'h12);
        cycle(1'b1, 1'b0, 8'h34);
        check("t5_busy_pre", bus.tx_busy, 1);
        check("t5_ovr_pre", bus.overrun, 1);
        #1 reset = 1'b1;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", bus.tx_busy, 0);
        check("t5_rst_active", tx_active, 0);
        check("t5_rst_overrun", bus.overrun, 0);
        repeat (3) idle();
        #1 reset = 1'b0;
        run_ticks(1);
        clear_capture();
        cycle(1'b1, 1'b0, 8'h01);
        wait_idle("t5_idle");
        add_byte(8'h01);
        add_idle(1);
        compare("t5_frame");

        // Strobe coincident with a tick while idle: load waits for the next tick
        while ((cyc + 1) % 4 != 0) idle();
        clear_capture();
        cycle(1'b1, 1'b0, 8'hA5);
        check("t6_tx_coinc", tx, 1);
        check("t6_busy_coinc", bus.tx_busy, 1);
        wait_idle("t6_idle");
        add_idle(1);
        add_byte(8'hA5);
        add_idle(1);
        compare("t6_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
